// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, parity modes and width helper for the UART receiver
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Smallest width w such that 2**w >= value
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width = width + 1;
        return width;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive FIFO with power-of-two depth and pop-through-full support
`timescale 1ns/1ps
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_10Hz,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are only visible while the FIFO holds data
    always_ff @(posedge clk_10Hz) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_10Hz) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - configurable UART receiver with majority voting and error pulses
`timescale 1ns/1ps
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 1042,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk_10Hz,
    input  logic       reset,
    input  logic       rx_bit,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CNT_W = clog2(CLK_PER_BIT);
    localparam int HALF  = CLK_PER_BIT / 2;

    rx_state_t            state;
    rx_state_t            state_next;
    logic                 sync1;
    logic                 sync2;
    logic                 rx_prev;
    logic [1:0]           warm;
    logic                 armed;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic                 s_early;
    logic                 s_mid;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 stop_fail;

    logic                 rx_s;
    logic                 fall;
    logic                 at_early;
    logic                 at_mid;
    logic                 at_vote;
    logic                 at_end;
    logic                 vote;
    logic                 parity_ok;
    logic                 stop_bad;
    logic                 par_bad;
    logic                 frame_done;
    logic                 push_frame;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;

    assign rx_s     = sync2;
    // An edge counts only once the line has been seen high after reset
    assign fall     = armed && rx_prev && !rx_s;
    assign at_early = (cnt == CNT_W'(HALF - 1));
    assign at_mid   = (cnt == CNT_W'(HALF));
    assign at_vote  = (cnt == CNT_W'(HALF + 1));
    assign at_end   = (cnt == CNT_W'(CLK_PER_BIT - 1));
    assign vote     = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);

    assign parity_ok = (PARITY == PARITY_ODD) ? (^shreg ^ par_bit) : !(^shreg ^ par_bit);
    assign par_bad   = (PARITY != PARITY_NONE) && !parity_ok;
    assign stop_bad  = stop_fail || !vote;
    assign push_frame = frame_done && !stop_bad && !par_bad;

    assign fifo_pop = rx_valid && rx_ready;
    assign rx_valid = !fifo_empty;
    assign rx_data  = 8'(fifo_data);

    // Synchroniser, edge history and post-reset arming of the edge detector
    always_ff @(posedge clk_10Hz) begin
        if (!reset) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            rx_prev <= 1'b1;
            warm    <= 2'b00;
            armed   <= 1'b0;
        end else begin
            sync1   <= rx_bit;
            sync2   <= sync1;
            rx_prev <= sync2;
            warm    <= {warm[0], 1'b1};
            armed   <= armed || (warm[1] && sync2);
        end
    end

    // FSM state register
    always_ff @(posedge clk_10Hz) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next-state logic; the frame is decided at the final stop-bit vote
    always_comb begin
        state_next = state;
        frame_done = 1'b0;
        case (state)
            ST_IDLE:  if (fall) state_next = ST_START;
            ST_START: begin
                if (at_vote && vote)  state_next = ST_IDLE;
                else if (at_end)      state_next = ST_DATA;
            end
            ST_DATA: begin
                if (at_end && bit_idx == 3'(DATA_BITS - 1))
                    state_next = (PARITY == PARITY_NONE) ? ST_STOP : ST_PAR;
            end
            ST_PAR:   if (at_end) state_next = ST_STOP;
            ST_STOP: begin
                if (at_vote && stop_idx == 1'(STOP_BITS - 1)) begin
                    state_next = ST_IDLE;
                    frame_done = 1'b1;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Bit-period counter, sample capture and frame assembly
    always_ff @(posedge clk_10Hz) begin
        if (!reset) begin
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            s_early   <= 1'b1;
            s_mid     <= 1'b1;
            shreg     <= '0;
            par_bit   <= 1'b0;
            stop_fail <= 1'b0;
        end else begin
            if (state_next == ST_IDLE)  cnt <= '0;
            else if (state == ST_IDLE)  cnt <= CNT_W'(1);
            else if (at_end)            cnt <= '0;
            else                        cnt <= cnt + CNT_W'(1);

            if (at_early) s_early <= rx_s;
            if (at_mid)   s_mid   <= rx_s;

            if (state == ST_IDLE) begin
                bit_idx   <= '0;
                stop_idx  <= 1'b0;
                stop_fail <= 1'b0;
            end
            if (state == ST_DATA && at_vote) shreg <= {vote, shreg[DATA_BITS-1:1]};
            if (state == ST_DATA && at_end)  bit_idx <= bit_idx + 3'd1;
            if (state == ST_PAR && at_vote)  par_bit <= vote;
            if (state == ST_STOP && at_vote) stop_fail <= stop_fail || !vote;
            if (state == ST_STOP && at_end)  stop_idx <= stop_idx + 1'b1;
        end
    end

    // Registered one-cycle status pulses; frame errors mask parity errors
    always_ff @(posedge clk_10Hz) begin
        if (!reset) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= frame_done && !stop_bad && par_bad;
            frame_err  <= frame_done && stop_bad;
            overrun    <= push_frame && fifo_full && !fifo_pop;
        end
    end

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_10Hz  (clk_10Hz),
        .reset     (reset),
        .push      (push_frame),
        .push_data (shreg),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - self-checking bench for uart_rx_cfg across four configurations
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    typedef struct {
        int         dut;
        logic [7:0] data;
        bit         bad_par;
        bit         bad_stop;
        bit         lat;
        bit         push;
        int         n_perr;
        int         n_ferr;
    } vec_t;

    typedef struct {
        int         dut;
        logic [7:0] data;
    } exp_t;

    logic       clk_10Hz = 1'b0;
    logic       reset;
    logic       rx_line  [4];
    logic       rx_ready [4];
    logic [7:0] rx_data  [4];
    logic       rx_valid [4];
    logic       perr     [4];
    logic       ferr     [4];
    logic       ovr      [4];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   perr_cnt [4] = '{0, 0, 0, 0};
    int   ferr_cnt [4] = '{0, 0, 0, 0};
    int   ovr_cnt  [4] = '{0, 0, 0, 0};
    exp_t exp_q [$];
    vec_t vecs [10];

    always #50 clk_10Hz = ~clk_10Hz;

    uart_rx_cfg #(.CLK_PER_BIT(1042), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk_10Hz(clk_10Hz), .reset(reset), .rx_bit(rx_line[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
        .rx_ready(rx_ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));
    uart_rx_cfg #(.CLK_PER_BIT(64), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
        .clk_10Hz(clk_10Hz), .reset(reset), .rx_bit(rx_line[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
        .rx_ready(rx_ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));
    uart_rx_cfg #(.CLK_PER_BIT(64), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
        .clk_10Hz(clk_10Hz), .reset(reset), .rx_bit(rx_line[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
        .rx_ready(rx_ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]));
    uart_rx_cfg #(.CLK_PER_BIT(64), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_d (
        .clk_10Hz(clk_10Hz), .reset(reset), .rx_bit(rx_line[3]), .rx_data(rx_data[3]), .rx_valid(rx_valid[3]),
        .rx_ready(rx_ready[3]), .parity_err(perr[3]), .frame_err(ferr[3]), .overrun(ovr[3]));

    function automatic int cpb(input int d);
        return (d == 0) ? 1042 : 64;
    endfunction

    function automatic int par_mode(input int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic int stop_cnt(input int d);
        return (d == 2) ? 2 : 1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk_10Hz);
            #1;
        end
    endtask

    task automatic hold_line(input int d, input logic v, input int n);
        rx_line[d] = v;
        wait_cycles(n);
    endtask

    // Drives one frame; bit b is on the line for cpb() cycles starting after the current edge
    task automatic send_frame(input int d, input logic [7:0] data, input bit bad_par,
                              input bit bad_stop, input bit chk_lat, input bit pop_at_vote);
        logic bits [16];
        logic p;
        int   c;
        int   nb;
        int   kv;
        c  = cpb(d);
        nb = 0;
        bits[nb] = 1'b0;
        nb = nb + 1;
        for (int i = 0; i < 8; i++) begin
            bits[nb] = data[i];
            nb = nb + 1;
        end
        if (par_mode(d) != 0) begin
            p = ^data;
            if (par_mode(d) == 1) p = ~p;
            bits[nb] = p ^ bad_par;
            nb = nb + 1;
        end
        for (int s = 0; s < stop_cnt(d); s++) begin
            bits[nb] = (bad_stop && s == stop_cnt(d) - 1) ? 1'b0 : 1'b1;
            nb = nb + 1;
        end
        // global bit-counter value of the last stop-bit vote
        kv = (nb - 1) * c + c / 2 + 1;
        for (int n = 0; n < nb * c; n++) begin
            rx_line[d] = bits[n / c];
            @(posedge clk_10Hz);
            #1;
            if (chk_lat && n == kv + 1) check("latency_at_vote", int'(rx_valid[d]), 0);
            if (chk_lat && n == kv + 2) check("latency_after_vote", int'(rx_valid[d]), 1);
            if (pop_at_vote && n == kv + 1) rx_ready[d] = 1'b1;
            if (pop_at_vote && n == kv + 2) rx_ready[d] = 1'b0;
        end
        rx_line[d] = 1'b1;
    endtask

    // Scoreboard: every pop is compared against the oldest expected frame
    always @(negedge clk_10Hz) begin
        for (int i = 0; i < 4; i++) begin
            if (perr[i]) perr_cnt[i] = perr_cnt[i] + 1;
            if (ferr[i]) ferr_cnt[i] = ferr_cnt[i] + 1;
            if (ovr[i])  ovr_cnt[i]  = ovr_cnt[i] + 1;
            if (reset && rx_valid[i] && rx_ready[i]) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pop", int'(rx_data[i]), -1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pop_dut", i, e.dut);
                    check("pop_data", int'(rx_data[i]), int'(e.data));
                end
            end
        end
    end

    initial begin
        #(130000 * 100);
        $display("FAIL watchdog: actual timeout, required end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int f0;
        int o0;
        vecs[0] = '{0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        vecs[1] = '{0, 8'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        vecs[2] = '{1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0};
        vecs[3] = '{1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[4] = '{1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        vecs[5] = '{1, 8'h96, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1};
        vecs[6] = '{2, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1};
        vecs[7] = '{2, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};
        vecs[8] = '{2, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0};
        vecs[9] = '{3, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0};

        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_line[i]  = 1'b1;
            rx_ready[i] = 1'b1;
        end
        wait_cycles(5);
        for (int i = 0; i < 4; i++) begin
            check("reset_valid", int'(rx_valid[i]), 0);
            check("reset_data", int'(rx_data[i]), 0);
            check("reset_pulses", int'(perr[i] | ferr[i] | ovr[i]), 0);
        end
        reset = 1'b1;
        wait_cycles(5);

        for (int v = 0; v < 10; v++) begin
            p0 = perr_cnt[vecs[v].dut];
            f0 = ferr_cnt[vecs[v].dut];
            o0 = ovr_cnt[vecs[v].dut];
            if (vecs[v].push) exp_q.push_back('{vecs[v].dut, vecs[v].data});
            send_frame(vecs[v].dut, vecs[v].data, vecs[v].bad_par, vecs[v].bad_stop, vecs[v].lat, 1'b0);
            wait_cycles(3);
            check("vec_parity_err", perr_cnt[vecs[v].dut] - p0, vecs[v].n_perr);
            check("vec_frame_err", ferr_cnt[vecs[v].dut] - f0, vecs[v].n_ferr);
            check("vec_overrun", ovr_cnt[vecs[v].dut] - o0, 0);
            check("vec_drained", int'(rx_valid[vecs[v].dut]), 0);
        end
        check("table_queue_empty", exp_q.size(), 0);

        // FIFO full: fifth frame dropped, sixth accepted alongside a pop of the head
        rx_ready[3] = 1'b0;
        o0 = ovr_cnt[3];
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back('{3, 8'(k)});
            send_frame(3, 8'(k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        wait_cycles(3);
        check("no_overrun_when_filling", ovr_cnt[3] - o0, 0);
        send_frame(3, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_cycles(3);
        check("overrun_on_fifth", ovr_cnt[3] - o0, 1);
        check("full_head_data", int'(rx_data[3]), 1);
        wait_cycles(20);
        check("head_stable", int'(rx_data[3]), 1);
        check("full_valid", int'(rx_valid[3]), 1);
        exp_q.push_back('{3, 8'h06});
        send_frame(3, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_cycles(3);
        check("no_overrun_push_pop", ovr_cnt[3] - o0, 1);
        check("head_after_push_pop", int'(rx_data[3]), 2);
        rx_ready[3] = 1'b1;
        for (int k = 0; k < 12 && rx_valid[3]; k++) wait_cycles(1);
        check("drain_valid", int'(rx_valid[3]), 0);
        check("drain_queue_empty", exp_q.size(), 0);

        // Short low glitch is a false start
        p0 = perr_cnt[0];
        f0 = ferr_cnt[0];
        hold_line(0, 1'b0, 300);
        hold_line(0, 1'b1, 1200);
        check("glitch_valid", int'(rx_valid[0]), 0);
        check("glitch_errors", (perr_cnt[0] - p0) + (ferr_cnt[0] - f0), 0);
        exp_q.push_back('{0, 8'h5A});
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_cycles(3);
        check("after_glitch_queue", exp_q.size(), 0);

        // Reset in the middle of data bit 4 with the line low, line stays low afterwards
        hold_line(0, 1'b0, 5 * 1042 + 521);
        reset = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        p0 = perr_cnt[0];
        f0 = ferr_cnt[0];
        hold_line(0, 1'b0, 200);
        hold_line(0, 1'b1, 2 * 1042);
        check("abort_valid", int'(rx_valid[0]), 0);
        check("abort_errors", (perr_cnt[0] - p0) + (ferr_cnt[0] - f0), 0);
        exp_q.push_back('{0, 8'hC3});
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
        wait_cycles(3);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_errors", (perr_cnt[0] - p0) + (ferr_cnt[0] - f0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
